// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported word memory between the instruction
// fetch port and the data load/store port of the core. Accesses are
// serialised with a fixed memory latency; contention alternates priority.
// Optional macro MEM_ARB_PERF_EN adds grant and conflict counters.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 2,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_ren,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_data,
    output logic              inst_stall,
    input  logic              d_ren,
    input  logic              d_wen,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_stall,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflict_cycles,
`endif
    output logic              ram_cs,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                owner_d, owner_d_n;
    logic                last_d, last_d_n;
    logic                cs_n, we_n;
    logic [ADDR_W-1:0]   addr_n;
    logic [DATA_W-1:0]   din_n, idata_n, drdata_n;

    logic                dreq, ireq, pick_d;
    logic [31:0]         i_word, d_word;

    // Request decode, arbitration pick and byte-to-word address conversion
    assign dreq   = d_ren | d_wen;
    assign ireq   = inst_ren;
    assign pick_d = dreq & ~(ireq & last_d);
    assign i_word = inst_addr >> 2;
    assign d_word = d_addr >> 2;

    // Stalls: a requesting port waits until its own DONE cycle; none during reset
    assign inst_stall = ~rst & ireq & ~((state == DONE) & ~owner_d);
    assign d_stall    = ~rst & dreq & ~((state == DONE) & owner_d);

    // State and registered-output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            owner_d   <= 1'b0;
            last_d    <= 1'b0;
            ram_cs    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            inst_data <= '0;
            d_rdata   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            owner_d   <= owner_d_n;
            last_d    <= last_d_n;
            ram_cs    <= cs_n;
            ram_we    <= we_n;
            ram_addr  <= addr_n;
            ram_din   <= din_n;
            inst_data <= idata_n;
            d_rdata   <= drdata_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        owner_d_n = owner_d;
        last_d_n  = last_d;
        cs_n      = ram_cs;
        we_n      = ram_we;
        addr_n    = ram_addr;
        din_n     = ram_din;
        idata_n   = inst_data;
        drdata_n  = d_rdata;

        case (state)
            IDLE: begin
                if (dreq | ireq) begin
                    owner_d_n = pick_d;
                    last_d_n  = pick_d;
                    we_n      = pick_d & d_wen;
                    addr_n    = pick_d ? ADDR_W'(d_word) : ADDR_W'(i_word);
                    din_n     = d_wdata;
                    cs_n      = 1'b1;
                    cnt_n     = CNT_W'(1);
                    state_n   = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == CNT_W'(MEM_LATENCY)) begin
                    if (!ram_we) begin
                        if (owner_d) begin
                            drdata_n = ram_dout;
                        end else begin
                            idata_n = ram_dout;
                        end
                    end
                    cs_n    = 1'b0;
                    we_n    = 1'b0;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    // Performance counters: grants per port and cycles with both ports stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_i_grants        <= '0;
            perf_d_grants        <= '0;
            perf_conflict_cycles <= '0;
        end else begin
            if ((state == IDLE) && (dreq | ireq)) begin
                if (pick_d) begin
                    perf_d_grants <= perf_d_grants + 32'(1);
                end else begin
                    perf_i_grants <= perf_i_grants + 32'(1);
                end
            end
            if (inst_stall && d_stall) begin
                perf_conflict_cycles <= perf_conflict_cycles + 32'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus
// randomized requesters, all checked each cycle against a timeline model.
module tb_mem_arbiter;

    localparam int unsigned L  = 2;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          inst_ren;
    logic [31:0]   inst_addr;
    logic [31:0]   inst_data;
    logic          inst_stall;
    logic          d_ren, d_wen;
    logic [31:0]   d_addr, d_wdata, d_rdata;
    logic          d_stall;
    logic          ram_cs, ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din, ram_dout;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_i_grants, perf_d_grants, perf_conflict_cycles;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.MEM_LATENCY(L), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data), .inst_stall(inst_stall),
        .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_stall(d_stall),
`ifdef MEM_ARB_PERF_EN
        .perf_i_grants(perf_i_grants), .perf_d_grants(perf_d_grants),
        .perf_conflict_cycles(perf_conflict_cycles),
`endif
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- timeline reference model ----------------
    // An access granted at edge g keeps ram_cs high after edges g..g+L-1,
    // captures read data at edge g+L, shows DONE until edge g+L+1, and the
    // next grant can happen at edge g+L+2.
    int unsigned n = 0;
    int unsigned m_g = 0;
    logic        m_valid = 1'b0;
    logic        m_active = 1'b0;
    logic        m_own_d, m_last_d, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0] m_din, m_idata, m_drdata;
    logic [31:0] m_ig, m_dg, m_conf;
    logic        es_i, es_d, gd;
    logic [31:0] wa;

    function automatic logic exp_cs();
        return m_active && ((n - m_g) < L);
    endfunction

    function automatic logic exp_done();
        return m_active && ((n - m_g) == L);
    endfunction

    function automatic logic exp_istall();
        return !rst && inst_ren && !(exp_done() && !m_own_d);
    endfunction

    function automatic logic exp_dstall();
        return !rst && (d_ren || d_wen) && !(exp_done() && m_own_d);
    endfunction

    always @(posedge clk) begin
        es_i = exp_istall();
        es_d = exp_dstall();
        n++;
        if (rst) begin
            m_valid  = 1'b1;
            m_active = 1'b0;
            m_own_d  = 1'b0;
            m_last_d = 1'b0;
            m_we     = 1'b0;
            m_addr   = '0;
            m_din    = '0;
            m_idata  = '0;
            m_drdata = '0;
            m_ig     = '0;
            m_dg     = '0;
            m_conf   = '0;
        end else if (m_valid) begin
            if (es_i && es_d) m_conf = m_conf + 32'(1);
            if (m_active && ((n - m_g) == L) && !m_we) begin
                if (m_own_d) m_drdata = ram_dout;
                else         m_idata  = ram_dout;
            end
            if (!m_active || ((n - m_g) >= L + 2)) begin
                m_active = 1'b0;
                if (d_ren || d_wen || inst_ren) begin
                    gd       = (d_ren || d_wen) && !(inst_ren && m_last_d);
                    m_active = 1'b1;
                    m_g      = n;
                    m_own_d  = gd;
                    m_last_d = gd;
                    m_we     = gd && d_wen;
                    wa       = (gd ? d_addr : inst_addr) >> 2;
                    m_addr   = wa[AW-1:0];
                    m_din    = d_wdata;
                    if (gd) m_dg = m_dg + 32'(1);
                    else    m_ig = m_ig + 32'(1);
                end
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("ram_cs",     32'(ram_cs),     32'(exp_cs()));
            check("ram_we",     32'(ram_we),     32'(exp_cs() && m_we));
            check("ram_addr",   32'(ram_addr),   32'(m_addr));
            check("ram_din",    ram_din,         m_din);
            check("inst_data",  inst_data,       m_idata);
            check("d_rdata",    d_rdata,         m_drdata);
            check("inst_stall", 32'(inst_stall), 32'(exp_istall()));
            check("d_stall",    32'(d_stall),    32'(exp_dstall()));
`ifdef MEM_ARB_PERF_EN
            check("perf_i_grants",  perf_i_grants,        m_ig);
            check("perf_d_grants",  perf_d_grants,        m_dg);
            check("perf_conflict",  perf_conflict_cycles, m_conf);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic is_d, input logic ren, input logic wen,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int stall_cyc, output int cs_cyc,
                          output logic [31:0] s_addr, output logic s_we, output logic [31:0] s_din);
        if (is_d) begin
            d_ren = ren; d_wen = wen; d_addr = addr; d_wdata = wdata;
        end else begin
            inst_ren = 1'b1; inst_addr = addr;
        end
        stall_cyc = 0; cs_cyc = 0; s_addr = '0; s_we = 1'b0; s_din = '0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ram_cs) begin
                cs_cyc++;
                s_addr = 32'(ram_addr);
                s_we   = ram_we;
                s_din  = ram_din;
            end
            if (!(is_d ? d_stall : inst_stall)) break;
            stall_cyc++;
        end
        step();
        d_ren = 1'b0; d_wen = 1'b0; inst_ren = 1'b0;
    endtask

    int          sc, cc, nrise, waited;
    logic [31:0] sa, sd;
    logic        sw, prev_cs, found, i_srv, d_srv;
    logic [31:0] g_addr [3];
    int unsigned r;

    initial begin
        rst = 1'b1; inst_ren = 1'b0; inst_addr = '0; d_ren = 1'b0; d_wen = 1'b0;
        d_addr = '0; d_wdata = '0; ram_dout = '0;

        // Reset state; requests during reset must not stall
        step();
        inst_ren = 1'b1; d_ren = 1'b1;
        @(negedge clk);
        check("rst_inst_stall", 32'(inst_stall), 32'(0));
        check("rst_d_stall",    32'(d_stall),    32'(0));
        check("rst_ram_cs",     32'(ram_cs),     32'(0));
        check("rst_inst_data",  inst_data,       32'h0);
        step();
        inst_ren = 1'b0; d_ren = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Fetch only
        ram_dout = 32'hDEAD_BEEF;
        do_req(1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, sc, cc, sa, sw, sd);
        check("fetch_stall_cycles", 32'(sc), 32'd3);
        check("fetch_cs_cycles",    32'(cc), 32'd2);
        check("fetch_ram_addr",     sa,      32'h4);
        check("fetch_ram_we",       32'(sw), 32'd0);
        check("fetch_inst_data",    inst_data, 32'hDEAD_BEEF);

        // Store
        ram_dout = 32'h5555_AAAA;
        do_req(1'b1, 1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, sc, cc, sa, sw, sd);
        check("store_stall_cycles", 32'(sc), 32'd3);
        check("store_cs_cycles",    32'(cc), 32'd2);
        check("store_ram_addr",     sa,      32'h41);
        check("store_ram_we",       32'(sw), 32'd1);
        check("store_ram_din",      sd,      32'h1234_5678);
        check("store_d_rdata",      d_rdata, 32'h0);

        // Read and write both high is a write
        ram_dout = 32'hCAFE_0000;
        do_req(1'b1, 1'b1, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, sc, cc, sa, sw, sd);
        check("rw_ram_we",   32'(sw), 32'd1);
        check("rw_ram_addr", sa,      32'h2);
        check("rw_d_rdata",  d_rdata, 32'h0);

        // Data load
        ram_dout = 32'h0BAD_F00D;
        do_req(1'b1, 1'b1, 1'b0, 32'h0000_0043, 32'h0, sc, cc, sa, sw, sd);
        check("load_ram_addr",  sa,        32'h10);
        check("load_d_rdata",   d_rdata,   32'h0BAD_F00D);
        check("load_inst_data", inst_data, 32'hDEAD_BEEF);

        // Contention from reset: D, I, D
        rst = 1'b1; inst_ren = 1'b1; d_ren = 1'b1;
        inst_addr = 32'h0000_0200; d_addr = 32'h0000_0100;
        step();
        step();
        rst = 1'b0;
        nrise = 0; prev_cs = 1'b0;
        for (int k = 0; k < 40 && nrise < 3; k++) begin
            @(negedge clk);
            if (ram_cs && !prev_cs) begin
                g_addr[nrise] = 32'(ram_addr);
                nrise++;
            end
            prev_cs = ram_cs;
        end
        check("cont_grants", 32'(nrise), 32'd3);
        check("cont_grant0", g_addr[0], 32'h40);
        check("cont_grant1", g_addr[1], 32'h80);
        check("cont_grant2", g_addr[2], 32'h40);
`ifdef MEM_ARB_PERF_EN
        check("cont_perf_d", perf_d_grants, 32'd2);
        check("cont_perf_i", perf_i_grants, 32'd1);
`endif
        step();
        inst_ren = 1'b0; d_ren = 1'b0;
        repeat (6) step();

        // Reset in the middle of an instruction read
        inst_ren = 1'b1; inst_addr = 32'h0000_0020; ram_dout = 32'h7777_7777;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            found = ram_cs;
        end
        check("mid_cs_seen", 32'(found), 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_inst_stall", 32'(inst_stall), 32'd0);
        check("mid_rst_d_stall",    32'(d_stall),    32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_ram_cs",     32'(ram_cs),     32'd0);
        check("mid_inst_data",  inst_data,       32'h0);
        check("mid_inst_stall", 32'(inst_stall), 32'd1);
        found = 1'b0; waited = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            @(negedge clk);
            found = !inst_stall;
            waited++;
        end
        check("mid_regrant_done", 32'(found), 32'd1);
        check("mid_regrant_data", inst_data,  32'h7777_7777);
        step();
        inst_ren = 1'b0;

        // Idle after reset: outputs hold reset values
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("idle_ram_cs",   32'(ram_cs) | 32'(inst_stall) | 32'(d_stall), 32'd0);
            check("idle_outputs",  inst_data | d_rdata | ram_din | 32'(ram_addr), 32'h0);
            step();
        end

        // Randomized requesters honouring the hold-while-stalled rule
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            i_srv = inst_ren && !inst_stall && !rst;
            d_srv = (d_ren || d_wen) && !d_stall && !rst;
            step();
            ram_dout = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            if (!inst_ren || i_srv) begin
                if ($urandom_range(0, 2) != 0) begin
                    inst_ren  = 1'b1;
                    inst_addr = $urandom;
                end else begin
                    inst_ren = 1'b0;
                end
            end
            if (!(d_ren || d_wen) || d_srv) begin
                if ($urandom_range(0, 2) != 0) begin
                    r = $urandom_range(0, 2);
                    d_ren   = (r != 1);
                    d_wen   = (r != 0);
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                end else begin
                    d_ren = 1'b0; d_wen = 1'b0;
                end
            end
        end
        rst = 1'b0; inst_ren = 1'b0; d_ren = 1'b0; d_wen = 1'b0;
        repeat (8) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
